// File: rtl/jt10_adpcm_romarb_if.sv
// ---------------------------------------------------------------------------
// jt10_adpcm_romarb_if
//
// Purpose:
//     Bundles the request/response handshakes of both ADPCM readers and the
//     shared memory port of the ADPCM ROM arbiter into one interface.
//
// Signals:
//     a_req/a_addr      ADPCM-A request level and byte address
//     a_data/a_ok       ADPCM-A returned byte and one-cycle valid strobe
//     b_req/b_addr      ADPCM-B request level and byte address
//     b_data/b_ok       ADPCM-B returned byte and one-cycle valid strobe
//     mem_addr/mem_cs   address and request towards the memory controller
//     mem_data/mem_ok   read byte and data-valid strobe from the controller
//
// Modports:
//     slave   the arbiter's view (consumes requests, drives responses/memory)
//     master  the environment's view (ADPCM readers plus memory controller)
// ---------------------------------------------------------------------------
interface jt10_adpcm_romarb_if #(
    parameter int AW = 24
);
    logic          a_req;
    logic [AW-1:0] a_addr;
    logic [7:0]    a_data;
    logic          a_ok;

    logic          b_req;
    logic [AW-1:0] b_addr;
    logic [7:0]    b_data;
    logic          b_ok;

    logic [AW-1:0] mem_addr;
    logic          mem_cs;
    logic [7:0]    mem_data;
    logic          mem_ok;

    modport slave (
        input  a_req, a_addr, b_req, b_addr, mem_data, mem_ok,
        output a_data, a_ok, b_data, b_ok, mem_addr, mem_cs
    );

    modport master (
        output a_req, a_addr, b_req, b_addr, mem_data, mem_ok,
        input  a_data, a_ok, b_data, b_ok, mem_addr, mem_cs
    );
endinterface

// File: rtl/jt10_adpcm_romarb.sv
// ---------------------------------------------------------------------------
// jt10_adpcm_romarb
//
// Purpose:
//     Shares a single ADPCM sample-ROM port between the ADPCM-A and ADPCM-B
//     readers. Requests are arbitrated round-robin, one memory cycle runs at
//     a time, and the fetched byte is returned with a one-cycle ok strobe.
//     An access that gets no mem_ok within TOUT cycles is aborted and
//     returns 8'h00.
//
// Parameters:
//     AW    address width of requesters and memory port (default 24)
//     TOUT  cycles mem_cs may stay high waiting for mem_ok (1..255)
//
// Ports:
//     clk        system clock
//     rst        synchronous, active-high reset
//     cache_clr  invalidates both cache entries (only with the cache built)
//     bus        jt10_adpcm_romarb_if.slave: both requester handshakes plus
//                the memory controller port
//
// Configuration:
//     JT10_ROMARB_CACHE_EN  when defined, each port keeps a one-entry cache
//                           (tag, byte, valid). A granted request hitting its
//                           port's entry skips the memory cycle. Undefined
//                           builds have no cache and ignore cache_clr.
// ---------------------------------------------------------------------------
module jt10_adpcm_romarb #(
    parameter int AW   = 24,
    parameter int TOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cache_clr,
    jt10_adpcm_romarb_if.slave    bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // The counter starts at 0 on the grant edge, so aborting when it holds
    // TOUT-1 keeps mem_cs high for exactly TOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          sel_q, sel_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_cs_q, mem_cs_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    a_data_q, a_data_d;
    logic          a_ok_q, a_ok_d;
    logic [7:0]    b_data_q, b_data_d;
    logic          b_ok_q, b_ok_d;

    logic          any_req;
    logic          grant_b;
    logic [AW-1:0] grant_addr;
    logic          mem_done;
    logic          mem_tout;
    logic          cache_hit;
    logic [7:0]    hit_byte;

    // Round-robin: B only wins a contention when A was served last.
    assign any_req    = bus.a_req | bus.b_req;
    assign grant_b    = bus.b_req & (~bus.a_req | (last_grant_q == SEL_A));
    assign grant_addr = grant_b ? bus.b_addr : bus.a_addr;

    assign mem_done = (state_q == ST_ACCESS) & mem_cs_q & bus.mem_ok;
    assign mem_tout = (state_q == ST_ACCESS) & ~mem_done & (cnt_q == CNT_LAST);

`ifdef JT10_ROMARB_CACHE_EN
    logic [AW-1:0] a_tag_q, a_tag_d;
    logic [7:0]    a_byte_q, a_byte_d;
    logic          a_valid_q, a_valid_d;
    logic [AW-1:0] b_tag_q, b_tag_d;
    logic [7:0]    b_byte_q, b_byte_d;
    logic          b_valid_q, b_valid_d;

    // The hit is judged on the port that arbitration picked, so a cached
    // port still respects round-robin order against the other one.
    assign cache_hit = grant_b ? (b_valid_q & (b_tag_q == bus.b_addr))
                               : (a_valid_q & (a_tag_q == bus.a_addr));
    assign hit_byte  = grant_b ? b_byte_q : a_byte_q;

    // Refill from completed memory cycles using the address latched at
    // grant; a timeout drops the entry; a clear overrides both.
    always_comb begin
        a_tag_d   = a_tag_q;
        a_byte_d  = a_byte_q;
        a_valid_d = a_valid_q;
        b_tag_d   = b_tag_q;
        b_byte_d  = b_byte_q;
        b_valid_d = b_valid_q;
        if (mem_done) begin
            if (sel_q == SEL_B) begin
                b_tag_d   = mem_addr_q;
                b_byte_d  = bus.mem_data;
                b_valid_d = 1'b1;
            end else begin
                a_tag_d   = mem_addr_q;
                a_byte_d  = bus.mem_data;
                a_valid_d = 1'b1;
            end
        end else if (mem_tout) begin
            if (sel_q == SEL_B) begin
                b_valid_d = 1'b0;
            end else begin
                a_valid_d = 1'b0;
            end
        end
        if (cache_clr) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_tag_q   <= '0;
            a_byte_q  <= 8'h00;
            a_valid_q <= 1'b0;
            b_tag_q   <= '0;
            b_byte_q  <= 8'h00;
            b_valid_q <= 1'b0;
        end else begin
            a_tag_q   <= a_tag_d;
            a_byte_q  <= a_byte_d;
            a_valid_q <= a_valid_d;
            b_tag_q   <= b_tag_d;
            b_byte_q  <= b_byte_d;
            b_valid_q <= b_valid_d;
        end
    end
`else
    logic unused_cache_clr;

    assign unused_cache_clr = cache_clr;
    assign cache_hit        = 1'b0;
    assign hit_byte         = 8'h00;
`endif

    // Arbitration and access sequencing. x_ok and x_data are registered on
    // the edge that leaves DONE, so with a zero-wait memory the strobe shows
    // up three edges after the request (two on a cache hit).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_cs_d     = mem_cs_q;
        data_d       = data_q;
        a_data_d     = a_data_q;
        a_ok_d       = 1'b0;
        b_data_d     = b_data_q;
        b_ok_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    sel_d = grant_b;
                    if (cache_hit) begin
                        // Hits leave last_grant alone.
                        data_d  = hit_byte;
                        state_d = ST_DONE;
                    end else begin
                        mem_addr_d   = grant_addr;
                        mem_cs_d     = 1'b1;
                        cnt_d        = 8'h00;
                        last_grant_d = grant_b;
                        state_d      = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                if (mem_done) begin
                    data_d   = bus.mem_data;
                    mem_cs_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (mem_tout) begin
                    data_d   = 8'h00;
                    mem_cs_d = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                // A requester that gave up meanwhile gets neither strobe
                // nor a data update.
                if (sel_q == SEL_B) begin
                    if (bus.b_req) begin
                        b_ok_d   = 1'b1;
                        b_data_d = data_q;
                    end
                end else begin
                    if (bus.a_req) begin
                        a_ok_d   = 1'b1;
                        a_data_d = data_q;
                    end
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= SEL_B;
            sel_q        <= SEL_A;
            cnt_q        <= 8'h00;
            mem_addr_q   <= '0;
            mem_cs_q     <= 1'b0;
            data_q       <= 8'h00;
            a_data_q     <= 8'h00;
            a_ok_q       <= 1'b0;
            b_data_q     <= 8'h00;
            b_ok_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_cs_q     <= mem_cs_d;
            data_q       <= data_d;
            a_data_q     <= a_data_d;
            a_ok_q       <= a_ok_d;
            b_data_q     <= b_data_d;
            b_ok_q       <= b_ok_d;
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_cs   = mem_cs_q;
    assign bus.a_data   = a_data_q;
    assign bus.a_ok     = a_ok_q;
    assign bus.b_data   = b_data_q;
    assign bus.b_ok     = b_ok_q;

endmodule

// File: tb/tb_jt10_adpcm_romarb.sv
// ---------------------------------------------------------------------------
// tb_jt10_adpcm_romarb
//
// Purpose:
//     Self-checking bench for jt10_adpcm_romarb. Stimulus pushes the expected
//     responses and memory addresses into queues; a monitor pops and compares
//     them whenever the DUT strobes an ok or raises mem_cs. A memory model
//     answers mem_cs with byte = addr[7:0] ^ addr[15:8] ^ 8'h5B.
//
// Configuration:
//     JT10_ROMARB_CACHE_EN  selects the cache-hit expectations of the last
//                           scenario.
// ---------------------------------------------------------------------------
module tb_jt10_adpcm_romarb;

    typedef struct packed {
        logic       is_b;
        logic [7:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cache_clr = 1'b0;

    jt10_adpcm_romarb_if #(.AW(24)) bus ();

    jt10_adpcm_romarb #(
        .AW   (24),
        .TOUT (255)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cache_clr (cache_clr),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    resp_t       exp_q[$];
    logic [23:0] addr_q[$];

    logic       mem_en      = 1'b1;
    int         mem_wait    = 0;
    logic       inject_ok   = 1'b0;
    logic [7:0] inject_data = 8'h00;
    int         cs_cycles   = 0;

    logic cs_prev       = 1'b0;
    int   cs_run        = 0;
    int   last_cs_len   = 0;
    int   cs_rise_count = 0;
    resp_t mon_e;

    // 100 MHz clock, posedge first.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] memByte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5B;
    endfunction

    // Memory controller model. It reacts 2 ns after each rising edge so it
    // sees the DUT's freshly registered mem_cs and never races the stimulus.
    // mem_ok is raised mem_wait cycles after mem_cs rises, or forced on
    // through inject_ok to model a stray late answer.
    always @(posedge clk) begin
        #2;
        if (inject_ok) begin
            bus.mem_ok   = 1'b1;
            bus.mem_data = inject_data;
        end else if (bus.mem_cs === 1'b1) begin
            if (mem_en && cs_cycles == mem_wait) begin
                bus.mem_ok   = 1'b1;
                bus.mem_data = memByte(bus.mem_addr);
            end else begin
                bus.mem_ok   = 1'b0;
                bus.mem_data = 8'h00;
            end
            cs_cycles++;
        end else begin
            bus.mem_ok   = 1'b0;
            bus.mem_data = 8'h00;
            cs_cycles    = 0;
        end
    end

    // Monitor: compares every ok strobe against the response scoreboard and
    // every mem_cs rise against the address scoreboard; also measures how
    // long mem_cs stays high.
    always @(negedge clk) begin
        if (bus.a_ok === 1'b1 || bus.b_ok === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("ok_without_pending", {30'd0, bus.a_ok, bus.b_ok}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("resp_port_b", {31'd0, bus.b_ok}, {31'd0, mon_e.is_b});
                checkOutput("resp_data", {24'd0, (bus.b_ok ? bus.b_data : bus.a_data)},
                            {24'd0, mon_e.data});
            end
        end
        if (bus.mem_cs === 1'b1 && cs_prev == 1'b0) begin
            cs_rise_count++;
            if (addr_q.size() == 0) begin
                checkOutput("mem_cs_unexpected", {31'd0, bus.mem_cs}, 32'd0);
            end else begin
                checkOutput("mem_addr", {8'd0, bus.mem_addr}, {8'd0, addr_q.pop_front()});
            end
        end
        if (bus.mem_cs === 1'b1) begin
            cs_run++;
        end else if (cs_run != 0) begin
            last_cs_len = cs_run;
            cs_run      = 0;
        end
        cs_prev = (bus.mem_cs === 1'b1);
    end

    // Issues one request, waits (bounded) for its ok, drops the request in
    // the ok cycle and checks latency plus the single-cycle strobe.
    task automatic applyStimulus(input string name, input logic is_b,
                                 input logic [23:0] addr, input logic [7:0] exp_byte,
                                 input logic exp_mem, input int exp_lat);
        int   edges = 0;
        logic seen  = 1'b0;
        exp_q.push_back('{is_b: is_b, data: exp_byte});
        if (exp_mem) addr_q.push_back(addr);
        if (is_b) begin
            bus.b_addr = addr;
            bus.b_req  = 1'b1;
        end else begin
            bus.a_addr = addr;
            bus.a_req  = 1'b1;
        end
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if ((is_b ? bus.b_ok : bus.a_ok) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        checkOutput({name, "_ok_seen"}, {31'd0, seen}, 32'd1);
        checkOutput({name, "_latency"}, edges, exp_lat);
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, "_ok_one_cycle"}, {30'd0, bus.a_ok, bus.b_ok}, 32'd0);
    endtask

    task automatic waitCsHigh(input string name);
        logic seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_cs === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Global guard so a broken DUT can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_a;
        int n_b;
        int n_ok;
        int rises;

        bus.a_req  = 1'b0;
        bus.a_addr = 24'h0;
        bus.b_req  = 1'b0;
        bus.b_addr = 24'h0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_a_ok", {31'd0, bus.a_ok}, 32'd0);
        checkOutput("rst_b_ok", {31'd0, bus.b_ok}, 32'd0);
        checkOutput("rst_a_data", {24'd0, bus.a_data}, 32'd0);
        checkOutput("rst_b_data", {24'd0, bus.b_data}, 32'd0);
        checkOutput("rst_mem_cs", {31'd0, bus.mem_cs}, 32'd0);
        checkOutput("rst_mem_addr", {8'd0, bus.mem_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single A request, zero-wait memory: 0x000100 -> 8'h5A in 3 edges.
        $display("[TB] single A request");
        applyStimulus("a_single", 1'b0, 24'h000100, 8'h5A, 1'b1, 3);

        // Contention after reset: A,B,A,B. A new address is presented in each
        // ok cycle so every round is a real memory access.
        $display("[TB] round-robin contention");
        pulseReset();
        exp_q.push_back('{is_b: 1'b0, data: 8'h59});
        exp_q.push_back('{is_b: 1'b1, data: 8'h3D});
        exp_q.push_back('{is_b: 1'b0, data: 8'h58});
        exp_q.push_back('{is_b: 1'b1, data: 8'h3E});
        addr_q.push_back(24'h000200);
        addr_q.push_back(24'h012345);
        addr_q.push_back(24'h000201);
        addr_q.push_back(24'h012346);
        n_a  = 0;
        n_b  = 0;
        n_ok = 0;
        bus.a_addr = 24'h000200;
        bus.b_addr = 24'h012345;
        bus.a_req  = 1'b1;
        bus.b_req  = 1'b1;
        for (int c = 0; c < 40 && n_ok < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.a_ok === 1'b1) begin
                n_a++;
                n_ok++;
                bus.a_addr = 24'h000201;
            end
            if (bus.b_ok === 1'b1) begin
                n_b++;
                n_ok++;
                bus.b_addr = 24'h012346;
            end
            if (n_ok >= 4) begin
                bus.a_req = 1'b0;
                bus.b_req = 1'b0;
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        checkOutput("rr_a_served", n_a, 2);
        checkOutput("rr_b_served", n_b, 2);
        repeat (2) @(negedge clk);

        // Timeout: memory never answers, mem_cs high 255 cycles, b_data 00.
        $display("[TB] timeout on B");
        mem_en = 1'b0;
        applyStimulus("b_timeout", 1'b1, 24'h00ABCD, 8'h00, 1'b1, 257);
        checkOutput("timeout_cs_len", last_cs_len, 255);
        mem_en = 1'b1;

        // Reset in ACCESS, stray mem_ok afterwards, then normal service.
        $display("[TB] reset mid-access");
        mem_en = 1'b0;
        addr_q.push_back(24'h000300);
        bus.a_addr = 24'h000300;
        bus.a_req  = 1'b1;
        waitCsHigh("rst_mid_cs_seen");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        bus.a_req = 1'b0;
        checkOutput("rst_mid_mem_cs", {31'd0, bus.mem_cs}, 32'd0);
        n_ok = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin
                inject_data = 8'hEE;
                inject_ok   = 1'b1;
            end else begin
                inject_ok = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (bus.a_ok === 1'b1 || bus.b_ok === 1'b1) n_ok++;
        end
        inject_ok = 1'b0;
        checkOutput("rst_mid_no_ok", n_ok, 0);
        checkOutput("rst_mid_a_data", {24'd0, bus.a_data}, 32'd0);
        mem_en = 1'b1;
        applyStimulus("after_rst", 1'b0, 24'h000400, 8'h5F, 1'b1, 3);

        // A drops its request while the access is in flight.
        $display("[TB] A abandons request");
        mem_wait = 2;
        addr_q.push_back(24'h000500);
        bus.a_addr = 24'h000500;
        bus.a_req  = 1'b1;
        waitCsHigh("drop_cs_seen");
        bus.a_req = 1'b0;
        n_ok = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.a_ok === 1'b1 || bus.b_ok === 1'b1) n_ok++;
        end
        checkOutput("drop_no_ok", n_ok, 0);
        checkOutput("drop_a_data_kept", {24'd0, bus.a_data}, 32'h5F);
        checkOutput("drop_cs_len", last_cs_len, 3);
        mem_wait = 0;

        // Same B address twice, then a cache clear and once more.
        $display("[TB] repeated B address");
        rises = cs_rise_count;
        applyStimulus("b_rep1", 1'b1, 24'h0A0000, 8'h5B, 1'b1, 3);
`ifdef JT10_ROMARB_CACHE_EN
        applyStimulus("b_rep2", 1'b1, 24'h0A0000, 8'h5B, 1'b0, 2);
        checkOutput("b_rep_cs_rises", cs_rise_count - rises, 1);
`else
        applyStimulus("b_rep2", 1'b1, 24'h0A0000, 8'h5B, 1'b1, 3);
        checkOutput("b_rep_cs_rises", cs_rise_count - rises, 2);
`endif
        cache_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cache_clr = 1'b0;
        rises = cs_rise_count;
        applyStimulus("b_rep3", 1'b1, 24'h0A0000, 8'h5B, 1'b1, 3);
        checkOutput("b_clr_cs_rises", cs_rise_count - rises, 1);

        repeat (4) @(negedge clk);
        checkOutput("resp_queue_drained", exp_q.size(), 0);
        checkOutput("addr_queue_drained", addr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
